// File: rtl/memwb_stage_reg.sv
// MEM/WB pipeline stage register: valid/ready handshake, 2-entry skid buffer, flush, saturating retire counter.
// Optional EX-stage forwarding outputs are enabled by defining MEMWB_FWD_EN.
module memwb_stage_reg #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_mem_rd_data,
   input  logic [DATA_W-1:0]     in_alu_data,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  in_mem_to_reg,
   input  logic                  in_reg_write,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic                  out_reg_write,
   output logic [DATA_W-1:0]     out_wb_data,
   output logic [CNT_W-1:0]      retire_cnt
`ifdef MEMWB_FWD_EN
   ,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd_addr,
   output logic [DATA_W-1:0]     fwd_data
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0]     mem_rd_data;
      logic [DATA_W-1:0]     alu_data;
      logic [REG_ADDR_W-1:0] rd_addr;
      logic                  mem_to_reg;
      logic                  reg_write;
   } entry_t;

   entry_t main_q;
   entry_t skid_q;
   entry_t in_entry;
   logic   main_valid;
   logic   skid_valid;
   logic   push;
   logic   pop;

   // Writes to x0 are squashed at capture so they can never reach the register file.
   assign in_entry.mem_rd_data = in_mem_rd_data;
   assign in_entry.alu_data    = in_alu_data;
   assign in_entry.rd_addr     = in_rd_addr;
   assign in_entry.mem_to_reg  = in_mem_to_reg;
   assign in_entry.reg_write   = in_reg_write & (in_rd_addr != '0);

   assign in_ready = !skid_valid;
   assign push     = in_valid & in_ready;
   assign pop      = main_valid & out_ready;

   assign out_valid     = main_valid;
   assign out_rd_addr   = main_q.rd_addr;
   assign out_reg_write = main_valid & main_q.reg_write;
   assign out_wb_data   = main_q.mem_to_reg ? main_q.mem_rd_data : main_q.alu_data;

   // Flush kills both valids and drops any incoming beat but leaves payload untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (pop) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end else if (push) begin
            main_q <= in_entry;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (push) begin
         if (!main_valid) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
         end else begin
            skid_q     <= in_entry;
            skid_valid <= 1'b1;
         end
      end
   end

   // Counts every WB handshake, including one that coincides with a flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= '0;
      end else if (pop && (retire_cnt != {CNT_W{1'b1}})) begin
         retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

`ifdef MEMWB_FWD_EN
   assign fwd_valid   = out_reg_write & !flush;
   assign fwd_rd_addr = out_rd_addr;
   assign fwd_data    = out_wb_data;
`endif

endmodule

// File: tb/tb_memwb_stage_reg.sv
// Self-checking bench for memwb_stage_reg: directed vector table, hand sequences and
// randomized traffic against a 2-deep FIFO reference model.
module tb_memwb_stage_reg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_mem_rd_data;
   logic [DATA_W-1:0]     in_alu_data;
   logic [REG_ADDR_W-1:0] in_rd_addr;
   logic                  in_mem_to_reg;
   logic                  in_reg_write;
   logic                  out_valid;
   logic                  out_ready;
   logic [REG_ADDR_W-1:0] out_rd_addr;
   logic                  out_reg_write;
   logic [DATA_W-1:0]     out_wb_data;
   logic [CNT_W-1:0]      retire_cnt;

   logic                  s_in_ready;
   logic                  s_out_valid;
   logic [REG_ADDR_W-1:0] s_out_rd_addr;
   logic                  s_out_reg_write;
   logic [DATA_W-1:0]     s_out_wb_data;
   logic [1:0]            s_retire_cnt;

`ifdef MEMWB_FWD_EN
   logic                  fwd_valid, s_fwd_valid;
   logic [REG_ADDR_W-1:0] fwd_rd_addr, s_fwd_rd_addr;
   logic [DATA_W-1:0]     fwd_data, s_fwd_data;
`endif

   always #5 clk = ~clk;

   memwb_stage_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_rd_data(in_mem_rd_data), .in_alu_data(in_alu_data),
      .in_rd_addr(in_rd_addr), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
      .out_wb_data(out_wb_data), .retire_cnt(retire_cnt)
`ifdef MEMWB_FWD_EN
      , .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data)
`endif
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation checks.
   memwb_stage_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_mem_rd_data(in_mem_rd_data), .in_alu_data(in_alu_data),
      .in_rd_addr(in_rd_addr), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_rd_addr(s_out_rd_addr), .out_reg_write(s_out_reg_write),
      .out_wb_data(s_out_wb_data), .retire_cnt(s_retire_cnt)
`ifdef MEMWB_FWD_EN
      , .fwd_valid(s_fwd_valid), .fwd_rd_addr(s_fwd_rd_addr), .fwd_data(s_fwd_data)
`endif
   );

   typedef struct {
      logic [DATA_W-1:0]     wb;
      logic [REG_ADDR_W-1:0] rd;
      logic                  rw;
   } beat_t;

   typedef struct {
      bit                    iv;
      bit                    ordy;
      bit                    fl;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     mem;
      logic [DATA_W-1:0]     alu;
      bit                    m2r;
      bit                    rw;
      bit                    e_ov;
      bit                    e_ir;
      bit                    e_orw;
      logic [DATA_W-1:0]     e_wb;
      logic [REG_ADDR_W-1:0] e_rd;
      int                    e_cnt;
   } vec_t;

   beat_t       q[$];
   beat_t       disp;
   int unsigned pops;
   int          checks = 0;
   int          errors = 0;
   vec_t        tbl[15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit iv, input bit ordy, input bit fl,
                                input logic [REG_ADDR_W-1:0] rd, input logic [DATA_W-1:0] mem,
                                input logic [DATA_W-1:0] alu, input bit m2r, input bit rw);
      in_valid       = iv;
      out_ready      = ordy;
      flush          = fl;
      in_rd_addr     = rd;
      in_mem_rd_data = mem;
      in_alu_data    = alu;
      in_mem_to_reg  = m2r;
      in_reg_write   = rw;
   endtask

   task automatic checkOutput();
      bit ne;
      ne = (q.size() > 0);
      chk("out_valid", out_valid, ne);
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_wb_data", out_wb_data, disp.wb);
      chk("out_rd_addr", out_rd_addr, disp.rd);
      chk("out_reg_write", out_reg_write, ne && disp.rw);
      chk("retire_cnt", retire_cnt, (pops > 65535) ? 65535 : pops);
      chk("sat_out_valid", s_out_valid, ne);
      chk("sat_retire_cnt", s_retire_cnt, (pops > 3) ? 3 : pops);
`ifdef MEMWB_FWD_EN
      chk("fwd_valid", fwd_valid, ne && disp.rw && !flush);
      chk("fwd_rd_addr", fwd_rd_addr, disp.rd);
      chk("fwd_data", fwd_data, disp.wb);
`endif
   endtask

   // One clock: check current outputs, advance the FIFO model across the edge.
   task automatic step();
      bit    push, pop;
      beat_t b;
      #1;
      checkOutput();
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      b.wb = in_mem_to_reg ? in_mem_rd_data : in_alu_data;
      b.rd = in_rd_addr;
      b.rw = in_reg_write && (in_rd_addr != 0);
      @(posedge clk);
      if (pop) pops++;
      if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(b);
         if (q.size() > 0) disp = q[0];
      end
      @(negedge clk);
   endtask

   task automatic resetNow();
      rst_n = 1'b0;
      #1;
      q.delete();
      disp = '{wb: '0, rd: '0, rw: 1'b0};
      pops = 0;
      checkOutput();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      resetNow();

      //          iv ordy fl rd  mem        alu        m2r rw  ov ir orw wb         rd  cnt
      tbl[0]  = '{1, 1, 0, 3,  32'h0,     32'h11,    0, 1,  1, 1, 1, 32'h11,    3,  0};
      tbl[1]  = '{1, 1, 0, 4,  32'hAA,    32'h0,     1, 1,  1, 1, 1, 32'hAA,    4,  1};
      tbl[2]  = '{0, 1, 0, 0,  32'h0,     32'h0,     0, 0,  0, 1, 0, 32'hAA,    4,  2};
      tbl[3]  = '{1, 0, 0, 5,  32'h0,     32'h100,   0, 1,  1, 1, 1, 32'h100,   5,  2};
      tbl[4]  = '{1, 0, 0, 6,  32'h200,   32'h0,     1, 1,  1, 0, 1, 32'h100,   5,  2};
      tbl[5]  = '{1, 0, 0, 7,  32'h0,     32'h300,   0, 1,  1, 0, 1, 32'h100,   5,  2};
      tbl[6]  = '{1, 1, 0, 7,  32'h0,     32'h300,   0, 1,  1, 1, 1, 32'h200,   6,  3};
      tbl[7]  = '{1, 1, 0, 7,  32'h0,     32'h300,   0, 1,  1, 1, 1, 32'h300,   7,  4};
      tbl[8]  = '{0, 1, 0, 0,  32'h0,     32'h0,     0, 0,  0, 1, 0, 32'h300,   7,  5};
      tbl[9]  = '{1, 0, 0, 0,  32'h0,     32'h5,     0, 1,  1, 1, 0, 32'h5,     0,  5};
      tbl[10] = '{0, 1, 0, 0,  32'h0,     32'h0,     0, 0,  0, 1, 0, 32'h5,     0,  6};
      tbl[11] = '{1, 0, 0, 8,  32'h0,     32'h400,   0, 1,  1, 1, 1, 32'h400,   8,  6};
      tbl[12] = '{1, 0, 0, 9,  32'h0,     32'h500,   0, 1,  1, 0, 1, 32'h400,   8,  6};
      tbl[13] = '{1, 1, 1, 10, 32'h0,     32'h600,   0, 1,  0, 1, 0, 32'h400,   8,  7};
      tbl[14] = '{0, 1, 0, 0,  32'h0,     32'h0,     0, 0,  0, 1, 0, 32'h400,   8,  7};

      for (int i = 0; i < 15; i++) begin
         applyStimulus(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].rd, tbl[i].mem,
                       tbl[i].alu, tbl[i].m2r, tbl[i].rw);
         step();
         #1;
         chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("vec%0d_out_reg_write", i), out_reg_write, tbl[i].e_orw);
         chk($sformatf("vec%0d_out_wb_data", i), out_wb_data, tbl[i].e_wb);
         chk($sformatf("vec%0d_out_rd_addr", i), out_rd_addr, tbl[i].e_rd);
         chk($sformatf("vec%0d_retire_cnt", i), retire_cnt, tbl[i].e_cnt);
      end

      // Fill both entries under back-pressure, then reset asynchronously mid-stream.
      applyStimulus(1, 0, 0, 12, 32'h0, 32'hC0DE, 0, 1);
      step();
      applyStimulus(1, 0, 0, 13, 32'hBEEF, 32'h0, 1, 1);
      step();
      #1;
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_out_valid", out_valid, 1'b1);
      resetNow();
      chk("reset_out_wb_data", out_wb_data, 32'h0);
      chk("reset_in_ready", in_ready, 1'b1);

      // Saturation of the 2-bit counter after more than three pops.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(i < 6, 1, 0, 5'(i + 1), 32'h0, 32'(i), 0, 1);
         step();
      end
      #1;
      chk("sat_after_pops", s_retire_cnt, 2'd3);
      chk("wide_after_pops", retire_cnt, 16'd6);

      for (int i = 0; i < 400; i++) begin
         if (i == 200) resetNow();
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 15) == 0,
                       ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                       $urandom, $urandom, 1'($urandom), 1'($urandom));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
